// File: rtl/conv_channel_accum_param_if.sv
// Stream bundle between the conv core and the channel accumulator.
// Latency: none (wires only).
// Backpressure: none; the consumer must take one sample per cycle.
//
// Ports carried:
//   relu_en        quasi-static ReLU enable
//   valid_bias_in  load strobe for bias_in
//   bias_in        bias for the next output channel
//   valid_in       pxl_in qualifier (gaps allowed)
//   pxl_in         signed partial sum
//   pxl_out        accumulated, biased, saturated result
//   valid_out      pxl_out qualifier
//   oc_done        pulse with the last pixel of each output channel
//   sat_flag       sticky saturation indicator
interface conv_channel_accum_param_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         relu_en;
    logic                         valid_bias_in;
    logic signed [DATA_WIDTH-1:0] bias_in;
    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] pxl_in;
    logic signed [DATA_WIDTH-1:0] pxl_out;
    logic                         valid_out;
    logic                         oc_done;
    logic                         sat_flag;

    // Producer side (conv core / bench).
    modport master (
        output relu_en, valid_bias_in, bias_in, valid_in, pxl_in,
        input  pxl_out, valid_out, oc_done, sat_flag
    );

    // Accumulator side.
    modport slave (
        input  relu_en, valid_bias_in, bias_in, valid_in, pxl_in,
        output pxl_out, valid_out, oc_done, sat_flag
    );
endinterface

// File: rtl/conv_channel_accum_param.sv
// Per-pixel channel accumulator: sums CHANNEL_NUM_IN partial-sum images, adds bias, saturates, optional ReLU.
// Latency: exactly 2 cycles from an accepted last-channel valid_in to valid_out.
// Backpressure: none; one sample per cycle sustained, gaps on valid_in allowed.
//
// Ports: clk, reset (sync, active-high) as plain ports; the stream, bias and
// result signals travel on bus (conv_channel_accum_param_if.slave).
module conv_channel_accum_param #(
    parameter int DATA_WIDTH      = 32,
    parameter int ACC_WIDTH       = 48,
    parameter int IMAGE_SIZE      = 23409,
    parameter int CHANNEL_NUM_IN  = 2048,
    parameter int CHANNEL_NUM_OUT = 2048,
    parameter int ADDR_WIDTH      = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    conv_channel_accum_param_if.slave   bus
);

    localparam int CH_W = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
    localparam int OC_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int EXT  = ACC_WIDTH - DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] PIX_LAST = ADDR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(CHANNEL_NUM_IN - 1);
    localparam logic [OC_W-1:0]       OC_LAST  = OC_W'(CHANNEL_NUM_OUT - 1);

    // DATA_WIDTH signed limits expressed in accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(EXT + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(EXT + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Position counters
    logic [ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [CH_W-1:0]       ch_cnt_q,  ch_cnt_d;
    logic [OC_W-1:0]       oc_cnt_q,  oc_cnt_d;

    // Bias staging
    logic signed [DATA_WIDTH-1:0] bias_pend_q, bias_pend_d;
    logic signed [DATA_WIDTH-1:0] bias_act_q,  bias_act_d;

    // Stage S1 registers
    logic                         s1_vld_q,   s1_vld_d;
    logic signed [DATA_WIDTH-1:0] s1_pxl_q,   s1_pxl_d;
    logic [ADDR_WIDTH-1:0]        s1_addr_q,  s1_addr_d;
    logic                         s1_first_q, s1_first_d;
    logic                         s1_last_q,  s1_last_d;

    // Output registers
    logic signed [DATA_WIDTH-1:0] pxl_out_q,   pxl_out_d;
    logic                         valid_out_q, valid_out_d;
    logic                         oc_done_q,   oc_done_d;
    logic                         sat_flag_q,  sat_flag_d;

    // Accumulator RAM (synchronous read, registered in the read cycle)
    logic [ACC_WIDTH-1:0] acc_ram [IMAGE_SIZE];
    logic [ACC_WIDTH-1:0] ram_rd_q;

    // S2 combinational datapath
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [DATA_WIDTH-1:0] sat_val;
    logic                         clamp;
    logic                         ram_we;
    logic                         out_fire;
    logic                         oc_start;

    // Counters and bias hand-over
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        ch_cnt_d    = ch_cnt_q;
        oc_cnt_d    = oc_cnt_q;
        bias_pend_d = bias_pend_q;
        bias_act_d  = bias_act_q;

        oc_start = bus.valid_in && (pix_cnt_q == '0) && (ch_cnt_q == '0);

        if (bus.valid_bias_in) begin
            bias_pend_d = bus.bias_in;
        end
        // A bias strobe coinciding with the first sample of an output channel
        // is forwarded so that channel uses the new value.
        if (oc_start) begin
            bias_act_d = bus.valid_bias_in ? bus.bias_in : bias_pend_q;
        end

        if (bus.valid_in) begin
            if (pix_cnt_q == PIX_LAST) begin
                pix_cnt_d = '0;
                if (ch_cnt_q == CH_LAST) begin
                    ch_cnt_d = '0;
                    oc_cnt_d = (oc_cnt_q == OC_LAST) ? '0 : oc_cnt_q + 1'b1;
                end else begin
                    ch_cnt_d = ch_cnt_q + 1'b1;
                end
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
    end

    // Stage S1 capture
    always_comb begin
        s1_vld_d   = bus.valid_in;
        s1_pxl_d   = s1_pxl_q;
        s1_addr_d  = s1_addr_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        if (bus.valid_in) begin
            s1_pxl_d   = bus.pxl_in;
            s1_addr_d  = pix_cnt_q;
            s1_first_d = (ch_cnt_q == '0);
            s1_last_d  = (ch_cnt_q == CH_LAST);
        end
    end

    // Stage S2 sum, saturation, ReLU, output register inputs
    always_comb begin
        sum     = '0;
        sat_val = '0;
        clamp   = 1'b0;

        // Channel 0 seeds the pixel with the bias instead of reading the RAM,
        // so stale contents from a previous channel or a reset never leak in.
        if (s1_first_q) begin
            sum = {{EXT{s1_pxl_q[DATA_WIDTH-1]}}, s1_pxl_q}
                + {{EXT{bias_act_q[DATA_WIDTH-1]}}, bias_act_q};
        end else begin
            sum = ram_rd_q + {{EXT{s1_pxl_q[DATA_WIDTH-1]}}, s1_pxl_q};
        end

        if (sum > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_WIDTH-1:0];
            clamp   = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_WIDTH-1:0];
            clamp   = 1'b1;
        end else begin
            sat_val = sum[DATA_WIDTH-1:0];
        end
        if (bus.relu_en && sat_val[DATA_WIDTH-1]) begin
            sat_val = '0;
        end

        // The last channel's sum goes straight out; its RAM slot is dead.
        ram_we   = s1_vld_q && !s1_last_q;
        out_fire = s1_vld_q && s1_last_q;

        pxl_out_d   = out_fire ? sat_val : pxl_out_q;
        valid_out_d = out_fire;
        oc_done_d   = out_fire && (s1_addr_q == PIX_LAST);
        sat_flag_d  = sat_flag_q || (out_fire && clamp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_q   <= '0;
            ch_cnt_q    <= '0;
            oc_cnt_q    <= '0;
            bias_pend_q <= '0;
            bias_act_q  <= '0;
            s1_vld_q    <= 1'b0;
            s1_pxl_q    <= '0;
            s1_addr_q   <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            pxl_out_q   <= '0;
            valid_out_q <= 1'b0;
            oc_done_q   <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            oc_cnt_q    <= oc_cnt_d;
            bias_pend_q <= bias_pend_d;
            bias_act_q  <= bias_act_d;
            s1_vld_q    <= s1_vld_d;
            s1_pxl_q    <= s1_pxl_d;
            s1_addr_q   <= s1_addr_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            pxl_out_q   <= pxl_out_d;
            valid_out_q <= valid_out_d;
            oc_done_q   <= oc_done_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    // RAM is never reset. Read and write of one address are always at least
    // IMAGE_SIZE samples apart, so no read/write forwarding is needed.
    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            ram_rd_q <= acc_ram[pix_cnt_q];
        end
        if (ram_we) begin
            acc_ram[s1_addr_q] <= sum;
        end
    end

    assign bus.pxl_out   = pxl_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.oc_done   = oc_done_q;
    assign bus.sat_flag  = sat_flag_q;

endmodule

// File: doc/conv_channel_accum_param.md
Name: conv_channel_accum_param

Overview:
- Parametrised per-pixel channel accumulator for the conv pipeline; generalised successor to the fixed 2048-channel adder.
- Sits directly after the 3x3 (dilated) conv core, in the same position as the fixed adder.
- Input is a channel-major stream of partial sums: IMAGE_SIZE pixels of input channel 0, then IMAGE_SIZE pixels of channel 1, and so on up to CHANNEL_NUM_IN, repeated for each output channel.
- Sums the partial sums per pixel in an IMAGE_SIZE-deep accumulator RAM, adds a per-output-channel bias, applies saturation and optional ReLU, and emits one image per output channel.

Parameters:
- DATA_WIDTH, 32, signed two's-complement width of pxl_in, bias_in and pxl_out.
- ACC_WIDTH, 48, internal accumulator width; must be >= DATA_WIDTH + clog2(CHANNEL_NUM_IN) + 1.
- IMAGE_SIZE, 23409, pixels per channel image (153x153); must be >= 4.
- CHANNEL_NUM_IN, 2048, partial-sum channels summed per output pixel; must be >= 1.
- CHANNEL_NUM_OUT, 2048, output channels per frame.
- ADDR_WIDTH, 15, accumulator RAM address width; must be >= clog2(IMAGE_SIZE).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- relu_en  in  1  quasi-static; 1 clamps negative outputs to 0.
- valid_bias_in  in  1  load strobe for bias_in.
- bias_in  in  DATA_WIDTH  bias for the next output channel.
- valid_in  in  1  pxl_in qualifier; gaps are allowed.
- pxl_in  in  DATA_WIDTH  signed partial sum.
- pxl_out  out  DATA_WIDTH  accumulated, biased, saturated result.
- valid_out  out  1  pxl_out qualifier.
- oc_done  out  1  one-cycle pulse coincident with the last pixel of each output channel.
- sat_flag  out  1  sticky; set on any output saturation.

Behaviour:
- Reset (synchronous, active-high) clears:
  - Outputs: pxl_out=0, valid_out=0, oc_done=0, sat_flag=0.
  - Internal: pix_cnt, ch_cnt, oc_cnt, bias_pend, bias_act, both pipeline valids.
  - RAM contents are not cleared; channel-0 overwrite makes clearing unnecessary.
- Reset mid-stream discards all in-flight data. The next valid_in is treated as pixel 0, channel 0, output channel 0.
- Counters advance only on valid_in:
  - pix_cnt wraps IMAGE_SIZE-1 -> 0 and increments ch_cnt.
  - ch_cnt wraps CHANNEL_NUM_IN-1 -> 0 and increments oc_cnt.
  - oc_cnt wraps CHANNEL_NUM_OUT-1 -> 0.
- Bias loading:
  - valid_bias_in writes bias_pend.
  - bias_act <= bias_pend when a valid_in is accepted with pix_cnt=0 and ch_cnt=0.
  - A bias load in the same cycle as that start is forwarded, so the new value is used.
  - A bias load at any other time affects only the next output channel.
- Pipeline stage S1 (cycle of valid_in): register pxl_in, pix_cnt, first=(ch_cnt==0), last=(ch_cnt==CHANNEL_NUM_IN-1); issue RAM read at pix_cnt.
- Pipeline stage S2 (next cycle):
  - sum = first ? sext(pxl_in)+sext(bias_act) : ram_rd + sext(pxl_in), computed in ACC_WIDTH.
  - If not last, write sum back to RAM at the same address.
  - If last, do not write; the RAM value is dead.
  - When CHANNEL_NUM_IN=1, first and last are both set: sum = pxl_in + bias, and the result goes out directly.
- Output register (one cycle after S2), last-channel samples only:
  - Saturate sum to DATA_WIDTH signed: clamp to max/min; on clamp, set sat_flag.
  - Then, if relu_en=1 and the result is negative, output 0. ReLU clamping does not set sat_flag.
  - valid_out=1 for that cycle. oc_done=1 additionally when the pixel index is IMAGE_SIZE-1.
- Latency is exactly 2 cycles from an accepted last-channel valid_in to valid_out. Non-last samples produce no output.
- valid_out is 0 in every other cycle; pxl_out holds its last value.
- RAM hazard: the same address is never read and written within 2 cycles, guaranteed by IMAGE_SIZE>=4. No forwarding logic is required.
- Throughput: one sample per cycle sustained; no backpressure.

Test Plan:
Bench parameters: IMAGE_SIZE=4, CHANNEL_NUM_IN=3, CHANNEL_NUM_OUT=2, DATA_WIDTH=16, ACC_WIDTH=24.
- Basic accumulation: bias 10; channels send pixel values {1,2,3,4}, {10,20,30,40}, {100,200,300,400} back-to-back -> valid_out exactly 2 cycles after each channel-2 pixel, pxl_out=121,232,343,454; oc_done only with 454.
- Gapped input and bias timing: same data with valid_in toggling every other cycle; bias 5 loaded mid output channel 0 -> output channel 0 results unchanged; output channel 1 uses bias 5; oc_cnt wraps to 0 after output channel 1.
- Saturation: channels {30000,...}, {30000,...}, {30000,...}, bias 0 -> pxl_out=32767, sat_flag=1 and stays 1 until reset. Repeat with -30000 in every channel -> pxl_out=-32768.
- ReLU: relu_en=1, channels {-5,...}, {1,...}, {1,...}, bias 0 -> pxl_out=0, sat_flag unchanged. With relu_en=0 -> pxl_out=-3.
- Reset mid-stream: assert reset after 6 accepted samples -> valid_out=0 and oc_done=0 from the following cycle. Restarted full frame gives correct sums with no stale RAM contribution.
- Simultaneous events: valid_bias_in in the same cycle as pixel 0 / channel 0 of an output channel -> the new bias is applied to that output channel.
